light_phase_sequencer: RTL

//   Parametrised N-phase traffic-light sequencer; generalises the 3-light countdown counter.

---
 rtl/light_pkg.sv | 28 ++
 rtl/light_dur_regfile.sv | 48 ++++
 rtl/light_phase_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared constants and helpers for the N-phase traffic-light sequencer.
package light_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2
    } light_phase_e;

    localparam int unsigned DEF_NUM_PHASES = 3;
    localparam int unsigned DEF_CNT_WIDTH  = 5;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

    // Packs three durations with phase i at bits [i*W +: W].
    function automatic logic [DEF_NUM_PHASES*DEF_CNT_WIDTH-1:0] pack_dur3(
        input logic [DEF_CNT_WIDTH-1:0] green,
        input logic [DEF_CNT_WIDTH-1:0] yellow,
        input logic [DEF_CNT_WIDTH-1:0] red
    );
        return {red, yellow, green};
    endfunction

endpackage

// File: rtl/light_dur_regfile.sv
// Per-phase duration registers: one write port, one read port with write bypass.
module light_dur_regfile
    import light_pkg::*;
#(
    parameter int unsigned pNUM_PHASES = 3,
    parameter int unsigned pCNT_WIDTH  = 5,
    parameter int unsigned pIDX_WIDTH  = 2,
    parameter logic [pNUM_PHASES*pCNT_WIDTH-1:0] pDEF_DUR = '0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [pIDX_WIDTH-1:0] wr_idx,
    input  logic [pCNT_WIDTH-1:0] wr_data,
    input  logic [pIDX_WIDTH-1:0] rd_idx,
    output logic [pCNT_WIDTH-1:0] rd_data
);

    localparam logic [pIDX_WIDTH:0] NUM = pNUM_PHASES[pIDX_WIDTH:0];

    logic [pCNT_WIDTH-1:0] mem [pNUM_PHASES];
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = we && ({1'b0, wr_idx} < NUM);
    assign rd_ok = {1'b0, rd_idx} < NUM;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < pNUM_PHASES; i++) begin
                mem[i] <= pDEF_DUR[i*pCNT_WIDTH +: pCNT_WIDTH];
            end
        end else if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A write landing on the index being loaded this cycle wins over the stored value.
    always_comb begin
        rd_data = '0;
        if (wr_ok && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end else if (rd_ok) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/light_phase_sequencer.sv
// N-phase round-robin light sequencer with programmable per-phase durations,
// hold, forced phase jump and one-hot lamp drive.
module light_phase_sequencer
    import light_pkg::*;
#(
    parameter int unsigned pNUM_PHASES = DEF_NUM_PHASES,
    parameter int unsigned pCNT_WIDTH  = DEF_CNT_WIDTH,
    parameter logic [pNUM_PHASES*pCNT_WIDTH-1:0] pDEF_DUR = pack_dur3(5'd14, 5'd2, 5'd17),
    localparam int unsigned pIDX_WIDTH = clog2_min1(pNUM_PHASES)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   hold,
    input  logic                   force_vld,
    input  logic [pIDX_WIDTH-1:0]  force_phase,
    input  logic                   cfg_we,
    input  logic [pIDX_WIDTH-1:0]  cfg_idx,
    input  logic [pCNT_WIDTH-1:0]  cfg_val,
    output logic [pIDX_WIDTH-1:0]  phase_idx,
    output logic [pNUM_PHASES-1:0] phase_onehot,
    output logic [pCNT_WIDTH-1:0]  cnt_out,
    output logic                   last,
    output logic                   phase_start
);

    localparam logic [pIDX_WIDTH:0]   NUM      = pNUM_PHASES[pIDX_WIDTH:0];
    localparam int unsigned           LAST_INT = pNUM_PHASES - 1;
    localparam logic [pIDX_WIDTH-1:0] LAST_PH  = LAST_INT[pIDX_WIDTH-1:0];

    logic [pIDX_WIDTH-1:0] phase_q;
    logic [pIDX_WIDTH-1:0] phase_d;
    logic [pIDX_WIDTH-1:0] next_phase;
    logic [pIDX_WIDTH-1:0] rd_idx;
    logic [pCNT_WIDTH-1:0] cnt_q;
    logic [pCNT_WIDTH-1:0] cnt_d;
    logic [pCNT_WIDTH-1:0] dur_rd;
    logic                  start_q;
    logic                  start_d;
    logic                  force_ok;

    assign force_ok   = force_vld && ({1'b0, force_phase} < NUM);
    assign next_phase = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
    // Only one load can happen per cycle, so a single read port serves both force and wrap.
    assign rd_idx     = force_ok ? force_phase : next_phase;

    light_dur_regfile #(
        .pNUM_PHASES (pNUM_PHASES),
        .pCNT_WIDTH  (pCNT_WIDTH),
        .pIDX_WIDTH  (pIDX_WIDTH),
        .pDEF_DUR    (pDEF_DUR)
    ) u_dur (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_val),
        .rd_idx  (rd_idx),
        .rd_data (dur_rd)
    );

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        if (force_ok) begin
            phase_d = force_phase;
            cnt_d   = dur_rd;
            start_d = 1'b1;
        end else if (!hold && en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                phase_d = next_phase;
                cnt_d   = dur_rd;
                start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= pIDX_WIDTH'(PH_GREEN);
            cnt_q   <= pDEF_DUR[pCNT_WIDTH-1:0];
            start_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        phase_onehot = '0;
        for (int unsigned i = 0; i < pNUM_PHASES; i++) begin
            phase_onehot[i] = (phase_q == i[pIDX_WIDTH-1:0]);
        end
    end

    assign phase_idx   = phase_q;
    assign cnt_out     = cnt_q;
    assign last        = (cnt_q == '0);
    assign phase_start = start_q;

endmodule
